// File: rtl/input_frame_loader_if.sv
// Bus bundle for input_frame_loader: frame/pixel command handshakes, load
// status, input SRAM write port and convolution engine start/busy.
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high; the master holds valid and its payload stable until
// that edge, and ready may depend on loader state but never on valid.
interface input_frame_loader_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [6:0]  frame_n;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        load_finish;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic        input_sram_write_enable;
  logic [11:0] input_sram_write_addresss;
  logic [15:0] input_sram_write_data;
  logic        dut_run;
  logic        dut_busy;

  modport master (
    output frame_valid, frame_n, pix_valid, pix_data, load_finish, dut_busy,
    input  frame_ready, pix_ready, load_busy, load_done, load_err,
    input  input_sram_write_enable, input_sram_write_addresss,
    input  input_sram_write_data, dut_run
  );

  modport slave (
    input  frame_valid, frame_n, pix_valid, pix_data, load_finish, dut_busy,
    output frame_ready, pix_ready, load_busy, load_done, load_err,
    output input_sram_write_enable, input_sram_write_addresss,
    output input_sram_write_data, dut_run
  );
endinterface

// File: rtl/input_frame_loader.sv
// input_frame_loader: packs a list of square signed-byte frames into the
// input SRAM as {header N, pixel words {hi,lo}...} per frame, closed by a
// 0xFFFF terminator. Optional macro LOADER_AUTORUN_EN: after the terminator
// pulse dut_run and wait for the engine's busy high/low before load_done.
// state_o exposes the FSM state (IDLE=0 HDR=1 PIX=2 TERM=3 RUN=4 WAIT_HI=5
// WAIT_LO=6).
module input_frame_loader (
  input  logic                 clk,
  input  logic                 reset_b,
  input_frame_loader_if.slave  bus,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PIX     = 3'd2,
    S_TERM    = 3'd3
`ifdef LOADER_AUTORUN_EN
    ,
    S_RUN     = 3'd4,
    S_WAIT_HI = 3'd5,
    S_WAIT_LO = 3'd6
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] wr_ptr_q, wr_ptr_d;
  logic [11:0] cnt_q, cnt_d;          // pixel byte index inside the frame
  logic [11:0] last_idx_q, last_idx_d; // N*N-1
  logic        last_q, last_d;        // final pixel word is being written
  logic [7:0]  hi_q, hi_d;            // even-index byte awaiting its partner
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Frame command admission: even N in 4..64 with room for header, pixel
  // words and a terminator. Range gating keeps the 13-bit sum from wrapping.
  logic [12:0] n13, sq_in, need;
  logic [11:0] half_in;
  logic        frame_ok;
  assign n13      = {6'b0, bus.frame_n};
  assign sq_in    = n13 * n13;
  assign half_in  = sq_in[12:1];
  assign need     = {1'b0, wr_ptr_q} + {1'b0, half_in} + 13'd2;
  assign frame_ok = !bus.frame_n[0] && (bus.frame_n >= 7'd4) &&
                    (bus.frame_n <= 7'd64) && (need <= 13'd4096);

`ifndef LOADER_AUTORUN_EN
  logic unused_busy;
  assign unused_busy = bus.dut_busy;
`endif

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset_b) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      last_idx_q <= '0;
      last_q     <= 1'b0;
      hi_q       <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      last_q     <= last_d;
      hi_q       <= hi_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next state and next datapath values; writes are staged one cycle ahead
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    last_d     = last_q;
    hi_d       = hi_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.frame_valid) begin
          if (frame_ok) begin
            state_d    = S_HDR;
            we_d       = 1'b1;
            addr_d     = wr_ptr_q;
            data_d     = {9'b0, bus.frame_n};
            wr_ptr_d   = wr_ptr_q + 12'd1;
            cnt_d      = '0;
            last_idx_d = sq_in[11:0] - 12'd1;
            last_d     = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.load_finish) begin
          state_d = S_TERM;
          we_d    = 1'b1;
          addr_d  = wr_ptr_q;
          data_d  = 16'hFFFF;
        end
      end
      S_HDR: state_d = S_PIX;
      S_PIX: begin
        if (last_q) begin
          state_d = S_IDLE;
          last_d  = 1'b0;
        end else if (bus.pix_valid) begin
          cnt_d = cnt_q + 12'd1;
          if (!cnt_q[0]) begin
            hi_d = bus.pix_data;
          end else begin
            we_d     = 1'b1;
            addr_d   = wr_ptr_q;
            data_d   = {hi_q, bus.pix_data};
            wr_ptr_d = wr_ptr_q + 12'd1;
            if (cnt_q == last_idx_q) last_d = 1'b1;
          end
        end
      end
`ifdef LOADER_AUTORUN_EN
      S_TERM:    state_d = S_RUN;
      S_RUN:     state_d = S_WAIT_HI;
      S_WAIT_HI: if (bus.dut_busy) state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!bus.dut_busy) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          wr_ptr_d = '0;
        end
      end
`else
      S_TERM: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        wr_ptr_d = '0;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake readiness, status and engine start decoded from state
  always_comb begin
    bus.frame_ready = (state_q == S_IDLE);
    bus.pix_ready   = (state_q == S_PIX) && !last_q;
    bus.load_busy   = (state_q != S_IDLE);
`ifdef LOADER_AUTORUN_EN
    bus.dut_run     = (state_q == S_RUN);
`else
    bus.dut_run     = 1'b0;
`endif
    state_o         = state_q;
  end

  assign bus.input_sram_write_enable   = we_q;
  assign bus.input_sram_write_addresss = addr_q;
  assign bus.input_sram_write_data     = data_q;
  assign bus.load_done                 = done_q;
  assign bus.load_err                  = err_q;

endmodule

// File: doc/input_frame_loader.md
INPUT_FRAME_LOADER -- requirements
Module: input_frame_loader

Interface
REQ-001 SHALL: clk  in  1  sole clock; all logic rising-edge.
REQ-002 SHALL: reset_b  in  1  reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL: frame_valid/frame_ready  in/out  1/1  frame command handshake; frame_n  in  7  frame side length N.
REQ-004 SHALL: pix_valid/pix_ready  in/out  1/1  pixel handshake; pix_data  in  8  signed pixel, row-major.
REQ-005 SHALL: load_finish  in  1  pulse: close the frame list; accepted only in IDLE.
REQ-006 SHALL: load_busy  out  1  high in every state except IDLE.
REQ-007 SHALL: load_done  out  1  one-cycle pulse, list complete; load_err  out  1  one-cycle pulse, frame command rejected.
REQ-008 SHALL: input_sram_write_enable  out  1, input_sram_write_addresss  out  12, input_sram_write_data  out  16  input SRAM write port.
REQ-009 SHALL: dut_run  out  1  start pulse to the convolution engine; dut_busy  in  1  engine busy.

Function
REQ-010 SHALL: states IDLE, HDR, PIX, TERM, RUN, WAIT_HI, WAIT_LO.
REQ-011 SHALL: IDLE: frame_ready=1; on frame_valid, frame accepted (go HDR) only if N even, 4<=N<=64 and wr_ptr+1+N*N/2+1 <= 4096; else load_err pulse, stay IDLE, no write.
REQ-012 SHALL: HDR: one-cycle write of {9'b0, N} at wr_ptr; wr_ptr+1; go PIX.
REQ-013 SHALL: PIX: pix_ready=1; even-index byte latched as high byte; odd-index byte completes word {hi, lo}, written the cycle after its handshake at wr_ptr; wr_ptr+1.
REQ-014 SHALL: PIX exits to IDLE the cycle after the write of byte N*N-1; frame_ready=0 in all states but IDLE.
REQ-015 SHALL: load_finish in IDLE -> TERM: write 0xFFFF at wr_ptr, wr_ptr unchanged; load_finish with zero frames writes 0xFFFF at address 0.
REQ-016 SHALL: load_finish and frame_valid in the same IDLE cycle: frame command wins; load_finish ignored.
REQ-017 SHALL: input_sram_write_enable high exactly one cycle per write, else 0; address/data hold last value when not writing.
REQ-018 SHALL: after TERM, load_done/autorun per Configuration; then wr_ptr=0 and IDLE.
REQ-019 SHALL: N*N/2 computed at 12 bits; capacity check compares 13-bit sum, no wrap-around accepted.

Reset
REQ-020 SHALL: reset_b high -> next edge: state IDLE, wr_ptr 0, all write outputs 0, dut_run 0, load_done 0, load_err 0, pixel latch 0.
REQ-021 SHALL: reset mid-frame abandons partial word (no write); next load starts at address 0.

Configuration
REQ-022 SHALL: macro LOADER_AUTORUN_EN defined: after TERM go RUN (dut_run=1 one cycle), WAIT_HI until dut_busy=1, WAIT_LO until dut_busy=0, load_done pulse the cycle after dut_busy falls.
REQ-023 SHALL: LOADER_AUTORUN_EN undefined: dut_run tied 0, dut_busy ignored, load_done pulse the cycle after the TERM write; RUN/WAIT states not built.

Verification
REQ-024 SHALL: N=4, pixels 0x01..0x10, load_finish -> writes addr0=0x0004, addr1=0x0102 ... addr8=0x0F10, addr9=0xFFFF.
REQ-025 SHALL: frames N=4 then N=6 -> second header 0x0006 at addr 9, 18 pixel words at 10..27, 0xFFFF at 28.
REQ-026 SHALL: frame_n=5 (and 66) -> load_err pulse, zero writes, next valid frame header at unchanged wr_ptr.
REQ-027 SHALL: two N=64 frames -> first at 0..2048; second rejected with load_err; load_finish writes 0xFFFF at 2049.
REQ-028 SHALL: reset_b high after 3 bytes of N=4 -> write_enable 0 next cycle, no write of byte pair 2; reload writes header at 0.
REQ-029 SHALL: LOADER_AUTORUN_EN, dut_busy high 10 cycles after dut_run -> single dut_run pulse, load_done one cycle after dut_busy falls, load_busy low same cycle.
